// File: rtl/fas_tol_checker.sv
// fas_tol_checker -- on-chip result checker for multi-lane datapath outputs.
//
// Each accepted DUT beat is compared against a golden word from an external
// synchronous ROM. The ROM read is issued on the accept cycle and its data
// arrives one cycle later, when the registered DUT beat is compared.
// A field passes when the signed modular difference is within +/-TOL.
// Failing lanes are counted with saturation at FAIL_LIMIT. Reaching the
// limit aborts the run. After NUM_BEATS beats a pass/fail verdict is given.
//
// Optional feature macro: FAS_TOL_CHECKER_FIRST_ERR_EN
//   When defined, the module records the lowest failing lane of the first
//   failing beat and drives it on the first_err_* ports.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              arm/restart a run (single-cycle pulse)
//   dut_valid/dut_data DUT output beat (lane 0 field 0 in the LSBs)
//   gold_rd/gold_addr  golden ROM read request (combinational)
//   gold_data          golden word, valid one cycle after gold_rd
//   busy/done/pass     run status; pass is meaningful only when done=1
//   fail_cnt           failing lanes so far (saturating)
//   beat_cnt           beats accepted in this run
//   err_pulse          one cycle high for each compared beat that had a failure
//   first_err_*        first-failure capture (optional)
module fas_tol_checker #(
  parameter int LANES      = 16,
  parameter int FIELDS     = 2,
  parameter int FIELD_W    = 16,
  parameter int TOL        = 3,
  parameter int NUM_BEATS  = 64,
  parameter int FAIL_LIMIT = 48,
  parameter int AW         = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  dut_valid,
  input  logic [LANES*FIELDS*FIELD_W-1:0]       dut_data,
  output logic                                  gold_rd,
  output logic [AW-1:0]                         gold_addr,
  input  logic [LANES*FIELDS*FIELD_W-1:0]       gold_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pass,
  output logic [$clog2(FAIL_LIMIT+1)-1:0]       fail_cnt,
  output logic [AW:0]                           beat_cnt,
  output logic                                  err_pulse
`ifdef FAS_TOL_CHECKER_FIRST_ERR_EN
  ,
  output logic                                  first_err_vld,
  output logic [AW:0]                           first_err_beat,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] first_err_lane,
  output logic [FIELDS*FIELD_W-1:0]             first_err_dut,
  output logic [FIELDS*FIELD_W-1:0]             first_err_gold
`endif
);

  localparam int DW     = LANES*FIELDS*FIELD_W;
  localparam int LW     = FIELDS*FIELD_W;
  localparam int FC_W   = $clog2(FAIL_LIMIT+1);
  localparam int NF_W   = $clog2(LANES+1);
  localparam int SUM_W  = FC_W + NF_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic signed [FIELD_W-1:0] TOL_S = FIELD_W'(TOL);

  typedef enum logic [1:0] {IDLE, RUN, DONE_PASS, DONE_FAIL} state_t;

  state_t          state_reg;
  logic [DW-1:0]   dut_reg;
  logic            cmp_vld_reg;   // a beat sits in the compare stage
  logic            cmp_last_reg;  // ...and it is the final beat of the run

  logic                    accept;
  logic [LANES*FIELDS-1:0] field_fail;
  logic [LANES-1:0]        lane_fail;
  logic [NF_W-1:0]         nfail;
  logic [SUM_W-1:0]        fail_sum;
  logic [FC_W-1:0]         fail_next;
  logic                    limit_hit;

  // A start in the same cycle wins over a beat offered in that cycle.
  assign accept    = (state_reg == RUN) && dut_valid && !start &&
                     (beat_cnt < (AW+1)'(NUM_BEATS));
  assign gold_rd   = accept;
  assign gold_addr = beat_cnt[AW-1:0];

  // Per-field tolerance check on the wrapped difference.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    for (genvar gf = 0; gf < FIELDS; gf++) begin : g_field
      localparam int IDX = gi*FIELDS + gf;
      logic signed [FIELD_W-1:0] diff;
      assign diff = dut_reg[IDX*FIELD_W +: FIELD_W] - gold_data[IDX*FIELD_W +: FIELD_W];
      assign field_fail[IDX] = (diff > TOL_S) || (diff < -TOL_S);
    end
    assign lane_fail[gi] = |field_fail[gi*FIELDS +: FIELDS];
  end

  always_comb begin
    nfail = '0;
    for (int i = 0; i < LANES; i++) begin
      nfail = nfail + NF_W'(lane_fail[i]);
    end
    fail_sum  = SUM_W'(fail_cnt) + SUM_W'(nfail);
    fail_next = (fail_sum >= SUM_W'(FAIL_LIMIT)) ? FC_W'(FAIL_LIMIT) : fail_sum[FC_W-1:0];
    limit_hit = (fail_next == FC_W'(FAIL_LIMIT));
  end

`ifdef FAS_TOL_CHECKER_FIRST_ERR_EN
  logic [AW:0]       cmp_beat_reg;
  logic [LANE_W-1:0] first_lane;

  // Scan from the top so the lowest failing lane is the one left selected.
  always_comb begin
    first_lane = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (lane_fail[i]) first_lane = LANE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cmp_beat_reg   <= '0;
      first_err_vld  <= 1'b0;
      first_err_beat <= '0;
      first_err_lane <= '0;
      first_err_dut  <= '0;
      first_err_gold <= '0;
    end else begin
      if (accept) cmp_beat_reg <= beat_cnt;
      if (state_reg == RUN && cmp_vld_reg && (|lane_fail) && !first_err_vld) begin
        first_err_vld  <= 1'b1;
        first_err_beat <= cmp_beat_reg;
        first_err_lane <= first_lane;
        first_err_dut  <= dut_reg[first_lane*LW +: LW];
        first_err_gold <= gold_data[first_lane*LW +: LW];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      dut_reg      <= '0;
      cmp_vld_reg  <= 1'b0;
      cmp_last_reg <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_cnt     <= '0;
      beat_cnt     <= '0;
      err_pulse    <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (start) begin
        state_reg    <= RUN;
        cmp_vld_reg  <= 1'b0;
        cmp_last_reg <= 1'b0;
        busy         <= 1'b1;
        done         <= 1'b0;
        pass         <= 1'b0;
        fail_cnt     <= '0;
        beat_cnt     <= '0;
      end else begin
        cmp_vld_reg <= accept;
        if (accept) begin
          dut_reg      <= dut_data;
          cmp_last_reg <= (beat_cnt == (AW+1)'(NUM_BEATS-1));
          beat_cnt     <= beat_cnt + (AW+1)'(1);
        end
        if (state_reg == RUN && cmp_vld_reg) begin
          fail_cnt  <= fail_next;
          err_pulse <= |lane_fail;
          if (limit_hit) begin
            // Abort: a beat accepted this cycle is dropped from the compare stage.
            state_reg   <= DONE_FAIL;
            cmp_vld_reg <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
          end else if (cmp_last_reg) begin
            state_reg <= (fail_next == '0) ? DONE_PASS : DONE_FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (fail_next == '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fas_tol_checker.sv
// Directed testbench for fas_tol_checker (LANES=2, FIELDS=2, FIELD_W=16,
// TOL=3, NUM_BEATS=4, FAIL_LIMIT=3, AW=2) with a small registered golden ROM.
module tb_fas_tol_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dut_valid;
  logic [63:0] dut_data;
  logic        gold_rd;
  logic [1:0]  gold_addr;
  logic [63:0] gold_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  fail_cnt;
  logic [2:0]  beat_cnt;
  logic        err_pulse;
`ifdef FAS_TOL_CHECKER_FIRST_ERR_EN
  logic        first_err_vld;
  logic [2:0]  first_err_beat;
  logic [0:0]  first_err_lane;
  logic [31:0] first_err_dut;
  logic [31:0] first_err_gold;
`endif

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_base;
  logic [63:0] gmem [4];

  fas_tol_checker #(
    .LANES(2), .FIELDS(2), .FIELD_W(16), .TOL(3),
    .NUM_BEATS(4), .FAIL_LIMIT(3), .AW(2)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_valid(dut_valid), .dut_data(dut_data),
    .gold_rd(gold_rd), .gold_addr(gold_addr), .gold_data(gold_data),
    .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .beat_cnt(beat_cnt), .err_pulse(err_pulse)
`ifdef FAS_TOL_CHECKER_FIRST_ERR_EN
    ,
    .first_err_vld(first_err_vld), .first_err_beat(first_err_beat),
    .first_err_lane(first_err_lane), .first_err_dut(first_err_dut),
    .first_err_gold(first_err_gold)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous golden ROM: data one cycle after the read request.
  always @(posedge clk) begin
    if (gold_rd) gold_data <= gmem[gold_addr];
  end

  always @(negedge clk) begin
    if (err_pulse === 1'b1) err_seen++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected simulation end");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pack(input logic [15:0] l0f0, input logic [15:0] l0f1,
                                       input logic [15:0] l1f0, input logic [15:0] l1f1);
    return {l1f1, l1f0, l0f1, l0f0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for one cycle; it must be accepted at the given address.
  task automatic send(input logic [63:0] d, input logic [1:0] addr);
    dut_valid = 1'b1;
    dut_data  = d;
    #1;
    chk("gold_rd_on_accept", gold_rd, 1'b1);
    chk("gold_addr", gold_addr, addr);
    tick();
    dut_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dut_valid = 1'b0; dut_data = '0;
    for (int i = 0; i < 4; i++) gmem[i] = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    // ---------------- reset state ----------------
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_fail_cnt", fail_cnt, 2'd0);
    chk("rst_beat_cnt", beat_cnt, 3'd0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_gold_rd", gold_rd, 1'b0);
    chk("rst_gold_addr", gold_addr, 2'd0);
    $display("step reset: busy=%0b done=%0b fail_cnt=%0d", busy, done, fail_cnt);

    // ---------------- exact match ----------------
    gmem[0] = pack(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    gmem[1] = pack(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    gmem[2] = pack(16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000);
    gmem[3] = pack(16'hABCD, 16'h1234, 16'h5678, 16'h9ABC);
    err_base = err_seen;
    pulse_start();
    chk("s1_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) send(gmem[i], 2'(i));
    chk("s1_done_t1", done, 1'b0);
    tick();
    chk("s1_done", done, 1'b1);
    chk("s1_pass", pass, 1'b1);
    chk("s1_busy_end", busy, 1'b0);
    chk("s1_fail_cnt", fail_cnt, 2'd0);
    chk("s1_beat_cnt", beat_cnt, 3'd4);
`ifdef FAS_TOL_CHECKER_FIRST_ERR_EN
    chk("s1_first_err_vld", first_err_vld, 1'b0);
`endif
    dut_valid = 1'b1; dut_data = gmem[0];
    #1;
    chk("s1_gold_rd_after_done", gold_rd, 1'b0);
    tick();
    dut_valid = 1'b0;
    chk("s1_beat_cnt_hold", beat_cnt, 3'd4);
    chk("s1_err_pulses", err_seen - err_base, 0);
    $display("step exact: done=%0b pass=%0b fail_cnt=%0d", done, pass, fail_cnt);

    // ---------------- tolerance edges ----------------
    gmem[0] = pack(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    gmem[1] = pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    gmem[2] = pack(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    gmem[3] = pack(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    err_base = err_seen;
    pulse_start();
    send(pack(16'h1003, 16'h0FFD, 16'h1003, 16'h0FFD), 2'd0);
    send(pack(16'h0002, 16'h0002, 16'h0002, 16'h0002), 2'd1);
    chk("s2_err_b0", err_pulse, 1'b0);
    send(pack(16'h1000, 16'h1000, 16'h1000, 16'h1004), 2'd2);
    chk("s2_fail_cnt_b1", fail_cnt, 2'd0);
    chk("s2_err_b1", err_pulse, 1'b0);
    send(gmem[3], 2'd3);
    chk("s2_err_b2", err_pulse, 1'b1);
    chk("s2_fail_cnt_b2", fail_cnt, 2'd1);
    tick();
    chk("s2_done", done, 1'b1);
    chk("s2_pass", pass, 1'b0);
    chk("s2_fail_cnt", fail_cnt, 2'd1);
    chk("s2_err_pulses", err_seen - err_base, 1);
    $display("step tolerance: done=%0b pass=%0b fail_cnt=%0d", done, pass, fail_cnt);

    // ---------------- fail limit ----------------
    for (int i = 0; i < 4; i++) gmem[i] = pack(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    pulse_start();
    send(pack(16'h2005, 16'h2000, 16'h2000, 16'h1FFB), 2'd0);
    tick();
    chk("s3_fail_cnt_b0", fail_cnt, 2'd2);
    chk("s3_err_b0", err_pulse, 1'b1);
    chk("s3_busy_b0", busy, 1'b1);
    send(pack(16'h2000, 16'h2004, 16'h2000, 16'h2000), 2'd1);
    tick();
    chk("s3_fail_cnt_limit", fail_cnt, 2'd3);
    chk("s3_done", done, 1'b1);
    chk("s3_busy", busy, 1'b0);
    chk("s3_pass", pass, 1'b0);
    dut_valid = 1'b1; dut_data = gmem[2];
    #1;
    chk("s3_gold_rd_b2", gold_rd, 1'b0);
    tick();
    chk("s3_gold_rd_b3", gold_rd, 1'b0);
    tick();
    dut_valid = 1'b0;
    chk("s3_beat_cnt", beat_cnt, 3'd2);
    chk("s3_fail_cnt_hold", fail_cnt, 2'd3);
    $display("step fail_limit: fail_cnt=%0d beat_cnt=%0d done=%0b", fail_cnt, beat_cnt, done);

    // ---------------- restart ----------------
    pulse_start();
    send(pack(16'h2005, 16'h2000, 16'h2000, 16'h2000), 2'd0);
    send(gmem[1], 2'd1);
    tick();
    chk("s4_fail_cnt_pre", fail_cnt, 2'd1);
    chk("s4_beat_cnt_pre", beat_cnt, 3'd2);
    start = 1'b1; dut_valid = 1'b1; dut_data = gmem[2];
    #1;
    chk("s4_gold_rd_with_start", gold_rd, 1'b0);
    tick();
    start = 1'b0; dut_valid = 1'b0;
    chk("s4_fail_cnt_clr", fail_cnt, 2'd0);
    chk("s4_beat_cnt_clr", beat_cnt, 3'd0);
    chk("s4_busy", busy, 1'b1);
    chk("s4_done", done, 1'b0);
    for (int i = 0; i < 4; i++) send(gmem[i], 2'(i));
    tick();
    chk("s4_done_end", done, 1'b1);
    chk("s4_pass", pass, 1'b1);
    $display("step restart: done=%0b pass=%0b fail_cnt=%0d", done, pass, fail_cnt);

    // ---------------- reset mid-run ----------------
    pulse_start();
    send(pack(16'h2005, 16'h2000, 16'h2000, 16'h2000), 2'd0);
    send(pack(16'h2000, 16'h2000, 16'h2000, 16'h2009), 2'd1);
    chk("s5_fail_cnt_pre", fail_cnt, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_busy", busy, 1'b0);
    chk("s5_done", done, 1'b0);
    chk("s5_fail_cnt", fail_cnt, 2'd0);
    chk("s5_beat_cnt", beat_cnt, 3'd0);
    chk("s5_err_pulse", err_pulse, 1'b0);
    dut_valid = 1'b1; dut_data = gmem[0];
    #1;
    chk("s5_gold_rd_idle", gold_rd, 1'b0);
    tick();
    chk("s5_gold_rd_idle2", gold_rd, 1'b0);
    chk("s5_err_pulse2", err_pulse, 1'b0);
    dut_valid = 1'b0;
    tick();
    chk("s5_beat_cnt_idle", beat_cnt, 3'd0);
    $display("step reset_mid_run: busy=%0b fail_cnt=%0d beat_cnt=%0d", busy, fail_cnt, beat_cnt);

`ifdef FAS_TOL_CHECKER_FIRST_ERR_EN
    // ---------------- first-error capture ----------------
    for (int i = 0; i < 4; i++) gmem[i] = pack(16'h3000, 16'h3000, 16'h3000, 16'h3000);
    pulse_start();
    send(gmem[0], 2'd0);
    send(pack(16'h3000, 16'h3000, 16'h3009, 16'h3000), 2'd1);
    send(gmem[2], 2'd2);
    chk("s6_err_b1", err_pulse, 1'b1);
    chk("s6_vld_with_err", first_err_vld, 1'b1);
    send(pack(16'h3000, 16'h2FF0, 16'h3000, 16'h3000), 2'd3);
    tick();
    chk("s6_fail_cnt", fail_cnt, 2'd2);
    chk("s6_done", done, 1'b1);
    chk("s6_first_err_vld", first_err_vld, 1'b1);
    chk("s6_first_err_beat", first_err_beat, 3'd1);
    chk("s6_first_err_lane", first_err_lane, 1'b1);
    chk("s6_first_err_dut", first_err_dut, 32'h3000_3009);
    chk("s6_first_err_gold", first_err_gold, 32'h3000_3000);
    pulse_start();
    chk("s6_vld_clr", first_err_vld, 1'b0);
    chk("s6_dut_clr", first_err_dut, 32'h0);
    $display("step first_err: beat=%0d lane=%0d", first_err_beat, first_err_lane);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
